sm_uart_rx: RTL and testbench

Serial receiver for the board's `UART_RX` pin. It moves data in the opposite direction from the CPU register readout: bytes travel from a host into the design, for example to select the register that is displayed or to feed a future I/O port. The block runs in the fast board clock domain, not the divided CPU clock. It delivers each received 8N1 byte through a valid/ack holding register, with overrun and framing-error reporting.

---
 rtl/sm_uart_rx.sv | 133 +++++++++++++
 tb/tb_sm_uart_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_uart_rx.sv
// 8N1 UART receiver for the board clock domain.
// Delivers bytes through a valid/ack holding register with overrun and framing-error flags.
module sm_uart_rx #(
  parameter int BAUD_DIV = 434,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       overrun,
  output logic       frame_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] MID  = CW'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t state, state_d;

  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic [7:0]    data_d;
  logic          valid_d, overrun_d, frame_err_d;
  logic          deliver;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_idx_d;
      shreg     <= shreg_d;
      data      <= data_d;
      valid     <= valid_d;
      overrun   <= overrun_d;
      frame_err <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt + CW'(1);
    bit_idx_d   = bit_idx;
    shreg_d     = shreg;
    data_d      = data;
    valid_d     = valid;
    overrun_d   = overrun;
    frame_err_d = 1'b0;
    deliver     = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt == MID) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_d     = '0;
          shreg_d   = {rx_s, shreg[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BRK;
          end
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    if (valid && ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    // A delivery on the ack edge refills the register instead of overrunning.
    if (deliver) begin
      if (!valid || ack) begin
        data_d  = shreg;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sm_uart_rx.sv
// Scoreboard bench for sm_uart_rx at 16 clocks per bit.
// Driver queues expected bytes/frame errors; a negedge monitor pops and compares.
module tb_sm_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid, overrun, frame_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         fe;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];

  logic last_valid = 1'b0;
  logic last_ack   = 1'b0;

  sm_uart_rx #(.BAUD_DIV(16), .HALF_DIV(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ack      (ack),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit fe, input logic [7:0] d);
    exp_t e;
    e.fe = fe;
    e.d  = d;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(16);
    end
    rx = stop;
    cyc(16);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  task automatic got(input bit fe, input logic [7:0] d);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got fe=%0b data=%02h expected nothing", fe, d);
    end else begin
      e = q.pop_front();
      if (e.fe != fe || (!fe && e.d !== d)) begin
        errors++;
        $display("FAIL sb_event: got fe=%0b data=%02h expected fe=%0b data=%02h",
                 fe, d, e.fe, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_valid = 1'b0;
      last_ack   = 1'b0;
    end else begin
      if (valid && (!last_valid || last_ack)) got(1'b0, data);
      if (frame_err) got(1'b1, 8'h00);
      last_valid = valid;
      last_ack   = ack;
    end
  end

  initial begin
    #1 rst = 1'b1;
    cyc(3);
    chk("rst_data", int'(data), 'h00);
    chk("rst_valid", int'(valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    rst = 1'b0;
    cyc(10);

    // nominal byte with exact latency
    push(1'b0, 8'hA5);
    fork
      send(8'hA5, 1'b1);
      begin
        cyc(154);
        chk("nom_valid_early", int'(valid), 0);
        cyc(1);
        chk("nom_valid", int'(valid), 1);
        chk("nom_data", int'(data), 'hA5);
        chk("nom_overrun", int'(overrun), 0);
        chk("nom_frame_err", int'(frame_err), 0);
      end
    join
    ack_pulse();
    chk("nom_ack_clear", int'(valid), 0);
    cyc(10);

    // start glitch
    rx = 1'b0;
    cyc(3);
    rx = 1'b1;
    cyc(40);
    chk("glitch_valid", int'(valid), 0);
    push(1'b0, 8'h3C);
    send(8'h3C, 1'b1);
    cyc(2);
    chk("glitch_next_data", int'(data), 'h3C);
    ack_pulse();
    cyc(10);

    // framing error then held-low break
    push(1'b1, 8'h00);
    send(8'h81, 1'b0);
    cyc(100);
    chk("brk_valid", int'(valid), 0);
    rx = 1'b1;
    cyc(20);
    push(1'b0, 8'h55);
    send(8'h55, 1'b1);
    cyc(2);
    chk("brk_next_data", int'(data), 'h55);
    chk("brk_next_valid", int'(valid), 1);
    ack_pulse();
    cyc(10);

    // overrun: second byte dropped
    push(1'b0, 8'h11);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    cyc(4);
    chk("ovr_data", int'(data), 'h11);
    chk("ovr_valid", int'(valid), 1);
    chk("ovr_flag", int'(overrun), 1);
    ack_pulse();
    chk("ovr_clr_valid", int'(valid), 0);
    chk("ovr_clr_flag", int'(overrun), 0);
    cyc(10);

    // ack coincident with the second stop-sample edge
    push(1'b0, 8'h11);
    push(1'b0, 8'h22);
    send(8'h11, 1'b1);
    fork
      send(8'h22, 1'b1);
      begin
        cyc(154);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("sim_data", int'(data), 'h22);
        chk("sim_valid", int'(valid), 1);
        chk("sim_overrun", int'(overrun), 0);
      end
    join
    cyc(10);

    // reset during bit 4 of 0xF0, with 0x22 still held
    fork
      send(8'hF0, 1'b1);
      begin
        cyc(85);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", int'(data), 'h00);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        chk("mid_rst_frame_err", int'(frame_err), 0);
        cyc(3);
        rst = 1'b0;
      end
    join
    cyc(20);
    chk("post_rst_valid", int'(valid), 0);
    push(1'b0, 8'h0F);
    send(8'h0F, 1'b1);
    cyc(2);
    chk("post_rst_data", int'(data), 'h0F);
    chk("post_rst_overrun", int'(overrun), 0);
    ack_pulse();
    cyc(5);

    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
